// File: rtl/prog_rom_bus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : prog_rom_bus                                                    |
// | Brief  : 68000-style bus slave to a byte-wide synchronous program-ROM    |
// |          pair. Optional sequential prefetch buffer: ROM_PREFETCH_EN.     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module prog_rom_bus #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_as_n,
  input  logic        cpu_rw,
  input  logic        rom_sel,
  input  logic [15:1] cpu_a,
  output logic [15:0] cpu_d_out,
  output logic        cpu_dtack_n,
  output logic [12:0] rom_a,
  output logic [1:0]  rom_bank,
  output logic        rom_ce,
  output logic        rom_oe,
  input  logic [7:0]  rom_d_hi,
  input  logic [7:0]  rom_d_lo
);

  localparam logic [1:0] c_wait_last = 2'(WAIT_CYCLES);

`ifdef ROM_PREFETCH_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    ACK      = 2'd2,
    PF_FETCH = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ACK   = 2'd2
  } state_t;
`endif

  state_t      r_state;
  logic [1:0]  r_wait;

  logic        w_req;
  logic [15:0] w_rom_data;
  logic        w_fetch_done;
  logic [15:0] w_fetch_data;

  assign w_req      = ~cpu_as_n & rom_sel;
  assign w_rom_data = {rom_d_hi, rom_d_lo};

`ifdef ROM_PREFETCH_EN
  logic        r_read;
  logic        r_hit;
  logic        r_pf_valid;
  logic [14:0] r_pf_tag;
  logic [15:0] r_pf_data;
  logic        w_hit;
  logic [14:0] w_addr;
  logic [14:0] w_next_addr;

  assign w_hit        = r_pf_valid && (r_pf_tag == cpu_a);
  assign w_addr       = {rom_bank, rom_a};
  assign w_next_addr  = w_addr + 15'd1;
  // A buffer hit completes on the first FETCH edge without touching the ROM.
  assign w_fetch_done = r_hit | (r_wait == c_wait_last);
  assign w_fetch_data = r_hit ? r_pf_data : w_rom_data;
`else
  assign w_fetch_done = (r_wait == c_wait_last);
  assign w_fetch_data = w_rom_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wait      <= 2'd0;
      cpu_dtack_n <= 1'b1;
      cpu_d_out   <= 16'h0000;
      rom_a       <= 13'd0;
      rom_bank    <= 2'd0;
      rom_ce      <= 1'b0;
      rom_oe      <= 1'b0;
`ifdef ROM_PREFETCH_EN
      r_read      <= 1'b0;
      r_hit       <= 1'b0;
      r_pf_valid  <= 1'b0;
      r_pf_tag    <= 15'd0;
      r_pf_data   <= 16'h0000;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            rom_bank <= cpu_a[15:14];
            rom_a    <= cpu_a[13:1];
            r_wait   <= 2'd0;
`ifdef ROM_PREFETCH_EN
            r_read   <= cpu_rw;
`endif
            if (cpu_rw) begin
              r_state <= FETCH;
`ifdef ROM_PREFETCH_EN
              r_hit  <= w_hit;
              rom_ce <= ~w_hit;
              rom_oe <= ~w_hit;
`else
              rom_ce <= 1'b1;
              rom_oe <= 1'b1;
`endif
            end else begin
              r_state     <= ACK;
              cpu_dtack_n <= 1'b0;
`ifdef ROM_PREFETCH_EN
              // ROM writes may be shadowed elsewhere; never trust the buffer.
              r_pf_valid  <= 1'b0;
`endif
            end
          end
        end

        FETCH: begin
          if (cpu_as_n) begin
            r_state <= IDLE;
            rom_ce  <= 1'b0;
            rom_oe  <= 1'b0;
          end else if (w_fetch_done) begin
            r_state     <= ACK;
            cpu_d_out   <= w_fetch_data;
            cpu_dtack_n <= 1'b0;
            rom_ce      <= 1'b0;
            rom_oe      <= 1'b0;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end

        ACK: begin
          if (cpu_as_n) begin
            cpu_dtack_n <= 1'b1;
`ifdef ROM_PREFETCH_EN
            if (r_read) begin
              r_state  <= PF_FETCH;
              rom_bank <= w_next_addr[14:13];
              rom_a    <= w_next_addr[12:0];
              rom_ce   <= 1'b1;
              rom_oe   <= 1'b1;
              r_wait   <= 2'd0;
            end else begin
              r_state <= IDLE;
            end
`else
            r_state <= IDLE;
`endif
          end
        end

`ifdef ROM_PREFETCH_EN
        PF_FETCH: begin
          // A CPU strobe arriving now simply waits; IDLE evaluates it afterwards.
          if (r_wait == c_wait_last) begin
            r_state    <= IDLE;
            r_pf_data  <= w_rom_data;
            r_pf_tag   <= w_addr;
            r_pf_valid <= 1'b1;
            rom_ce     <= 1'b0;
            rom_oe     <= 1'b0;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
`endif

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_rom_bus.sv
`default_nettype none
// Self-checking bench for prog_rom_bus: vector table, directed corner cases
// and a random transaction stream checked against a transaction-level model.
module tb_prog_rom_bus;

  localparam int W = 1;
`ifdef ROM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_as_n;
  logic        cpu_rw;
  logic        rom_sel;
  logic [15:1] cpu_a;
  logic [15:0] cpu_d_out;
  logic        cpu_dtack_n;
  logic [12:0] rom_a;
  logic [1:0]  rom_bank;
  logic        rom_ce;
  logic        rom_oe;
  logic [7:0]  rom_d_hi;
  logic [7:0]  rom_d_lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_rom_bus #(.WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_as_n    (cpu_as_n),
    .cpu_rw      (cpu_rw),
    .rom_sel     (rom_sel),
    .cpu_a       (cpu_a),
    .cpu_d_out   (cpu_d_out),
    .cpu_dtack_n (cpu_dtack_n),
    .rom_a       (rom_a),
    .rom_bank    (rom_bank),
    .rom_ce      (rom_ce),
    .rom_oe      (rom_oe),
    .rom_d_hi    (rom_d_hi),
    .rom_d_lo    (rom_d_lo)
  );

  // ROM contents as a pure function of the 15-bit word address.
  function automatic logic [15:0] rom_word(input logic [14:0] a);
    if (a == 15'h4123) return 16'hA55A;
    return {a[7:0] ^ 8'h3C, a[14:7]};
  endfunction

  // Synchronous ROM: data for an address is valid W clocks after it is presented.
  logic [14:0] pipe_a  [3];
  bit          pipe_ce [3];
  always @(posedge clk) begin
    pipe_a[0]  <= {rom_bank, rom_a};
    pipe_ce[0] <= rom_ce & rom_oe;
    for (int i = 1; i < 3; i++) begin
      pipe_a[i]  <= pipe_a[i-1];
      pipe_ce[i] <= pipe_ce[i-1];
    end
  end
  assign {rom_d_hi, rom_d_lo} = pipe_ce[W-1] ? rom_word(pipe_a[W-1]) : 16'hDEAD;

  // Transaction-level model state
  logic [15:0] m_data;
  bit          m_pf_valid;
  logic [14:0] m_pf_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_expect(input logic [14:0] a, input bit rw,
                              output logic [15:0] d, output int lat, output bit ce);
    if (!rw) begin
      d = m_data; lat = 0; ce = 1'b0;
    end else if (PF && m_pf_valid && m_pf_tag == a) begin
      d = rom_word(a); lat = 1; ce = 1'b0;
    end else begin
      d = rom_word(a); lat = 1 + W; ce = 1'b1;
    end
  endtask

  task automatic model_update(input logic [14:0] a, input bit rw, input logic [15:0] d);
    if (rw) begin
      m_data     = d;
      m_pf_valid = 1'b1;
      m_pf_tag   = a + 15'd1;
    end else begin
      m_pf_valid = 1'b0;
    end
  endtask

  task automatic do_cycle(input logic [14:0] a, input bit rw, input int hold,
                          input logic [15:0] exp_d, input int exp_lat, input bit exp_ce);
    int lat;
    bit ce_seen;
    @(negedge clk);
    cpu_as_n = 1'b0; cpu_rw = rw; rom_sel = 1'b1; cpu_a = a;
    @(posedge clk); #1;
    check("accept_addr", {rom_bank, rom_a}, a);
    lat = 0;
    ce_seen = rom_ce;
    while (cpu_dtack_n && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      ce_seen |= rom_ce;
    end
    check("dtack_latency", lat, exp_lat);
    check("rom_ce_used", ce_seen, exp_ce);
    check("read_data", cpu_d_out, exp_d);
    repeat (hold) @(posedge clk);
    #1 check("ack_hold", {cpu_dtack_n, cpu_d_out}, {1'b0, exp_d});
    @(negedge clk);
    cpu_as_n = 1'b1; rom_sel = 1'b0;
    @(posedge clk); #1;
    check("dtack_release", cpu_dtack_n, 1'b1);
    model_update(a, rw, exp_d);
    repeat (W + 4) @(posedge clk);
  endtask

  task automatic rand_cycle(input logic [14:0] a, input bit rw, input int hold);
    logic [15:0] d;
    int lat;
    bit ce;
    model_expect(a, rw, d, lat, ce);
    do_cycle(a, rw, hold, d, lat, ce);
  endtask

  typedef struct {
    logic [14:0] addr;
    bit          rw;
    int          hold;
    logic [15:0] exp_d;
    int          exp_lat;
    bit          exp_ce;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          seen;
    logic [14:0] prev;

    reset = 1'b1; cpu_as_n = 1'b1; cpu_rw = 1'b1; rom_sel = 1'b0; cpu_a = '0;
    m_data = 16'h0000; m_pf_valid = 1'b0; m_pf_tag = '0;

    tbl[0] = '{15'h4123, 1'b1, 3, 16'hA55A,           1 + W, 1'b1};
    tbl[1] = '{15'h0010, 1'b0, 0, 16'hA55A,           0,     1'b0};
    tbl[2] = '{15'h1555, 1'b1, 1, rom_word(15'h1555), 1 + W, 1'b1};
    tbl[3] = '{15'h2AAA, 1'b1, 0, rom_word(15'h2AAA), 1 + W, 1'b1};
    tbl[4] = '{15'h7FFE, 1'b0, 2, rom_word(15'h2AAA), 0,     1'b0};
    tbl[5] = '{15'h7FFF, 1'b1, 2, rom_word(15'h7FFF), 1 + W, 1'b1};
    tbl[6] = '{15'h0003, 1'b1, 0, rom_word(15'h0003), 1 + W, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_dtack", cpu_dtack_n, 1'b1);
    check("reset_data", cpu_d_out, 16'h0000);
    check("reset_rom", {rom_bank, rom_a, rom_ce, rom_oe}, 17'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      do_cycle(tbl[i].addr, tbl[i].rw, tbl[i].hold, tbl[i].exp_d, tbl[i].exp_lat, tbl[i].exp_ce);

    // Strobe with the region not selected: bus must be ignored.
    @(negedge clk);
    cpu_as_n = 1'b0; cpu_rw = 1'b1; rom_sel = 1'b0; cpu_a = 15'h0123;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!cpu_dtack_n || rom_ce) seen = 1'b1;
    end
    check("unselected_ignored", seen, 1'b0);
    @(negedge clk);
    cpu_as_n = 1'b1;

    // Abort: strobe released one clock into FETCH.
    @(negedge clk);
    cpu_as_n = 1'b0; cpu_rw = 1'b1; rom_sel = 1'b1; cpu_a = 15'h0ABC;
    @(posedge clk);
    @(negedge clk);
    cpu_as_n = 1'b1; rom_sel = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (!cpu_dtack_n) seen = 1'b1;
    end
    check("abort_no_dtack", seen, 1'b0);
    check("abort_ce_off", {rom_ce, rom_oe}, 2'b00);
    check("abort_data", cpu_d_out, m_data);

    // Random transaction stream
    prev = 15'h0100;
    for (int i = 0; i < 30; i++) begin
      logic [14:0] ra;
      ra = ($urandom_range(0, 1) == 1) ? prev + 15'd1 : 15'($urandom);
      rand_cycle(ra, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
      prev = ra;
    end

    // Reset while acknowledging a read
    @(negedge clk);
    cpu_as_n = 1'b0; cpu_rw = 1'b1; rom_sel = 1'b1; cpu_a = 15'h0555;
    lat = 0;
    @(posedge clk); #1;
    while (cpu_dtack_n && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("pre_reset_ack", cpu_dtack_n, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ack_dtack", cpu_dtack_n, 1'b1);
    check("reset_in_ack_outs", {cpu_d_out, rom_bank, rom_a, rom_ce, rom_oe}, 33'd0);
    @(negedge clk);
    reset = 1'b0; cpu_as_n = 1'b1; rom_sel = 1'b0;
    m_data = 16'h0000; m_pf_valid = 1'b0;
    @(posedge clk);

    // First request after reset is accepted immediately.
    rand_cycle(15'h0042, 1'b1, 0);

`ifdef ROM_PREFETCH_EN
    // Wrap-around prefetch hit, then invalidation by a write
    do_cycle(15'h7FFF, 1'b1, 0, rom_word(15'h7FFF), 1 + W, 1'b1);
    do_cycle(15'h0000, 1'b1, 1, rom_word(15'h0000), 1,     1'b0);
    do_cycle(15'h0005, 1'b0, 0, rom_word(15'h0000), 0,     1'b0);
    do_cycle(15'h0000, 1'b1, 0, rom_word(15'h0000), 1 + W, 1'b1);

    // Back-to-back request lands during PF_FETCH, then hits.
    @(negedge clk);
    cpu_as_n = 1'b0; cpu_rw = 1'b1; rom_sel = 1'b1; cpu_a = 15'h0100;
    lat = 0;
    @(posedge clk); #1;
    while (cpu_dtack_n && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_data", cpu_d_out, rom_word(15'h0100));
    @(negedge clk);
    cpu_as_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_as_n = 1'b0; cpu_a = 15'h0101;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (cpu_dtack_n && lat < 12);
    check("b2b_held_latency", lat, W + 3);
    check("b2b_held_data", cpu_d_out, rom_word(15'h0101));
    @(negedge clk);
    cpu_as_n = 1'b1; rom_sel = 1'b0;
    m_data = rom_word(15'h0101); m_pf_valid = 1'b1; m_pf_tag = 15'h0102;
    repeat (W + 4) @(posedge clk);
    rand_cycle(15'h0102, 1'b1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
